fifo_read_unit: RTL and testbench
=================================

// Module: fifo_read_unit
// PURPOSE
//  Read-side controller for the shared-clock FIFO. It sits downstream of the write-pointer unit and consumes its wr_ptr.
//  Owns rd_ptr, which is fed back to the write unit for its full flag, and produces the empty, almost-empty and fill-level flags.
//  Drives the synchronous-read buffer memory and presents read data through a 2-stage pipeline with a valid strobe.
// PARAMETERS
//  S         12          pointer width: [S-1] = wrap bit, [S-2:0] = index; DEPTH < 2**(S-1) required
//  DEPTH     150         number of FIFO entries; index counts 0..DEPTH-1 (non-power-of-2 allowed)
//  W         8           data width
//  AE_THRESH 4           o_almost_empty asserts when fill level <= AE_THRESH
// PORTS
//  rd_clk          in   1    sole clock, rising edge
//  rd_rst          in   1    synchronous, active-high reset
//  rd_en           in   1    consumer read request
//  wr_ptr          in   S    write pointer from the write unit (same clock domain)
//  mem_rd_data     in   W    memory read data, valid the cycle after mem_rd_en
//  rd_ptr          out  S    read pointer (registered), fed to the write unit
//  mem_rd_en       out  1    memory read strobe (combinational)
//  mem_rd_addr     out  S-1  memory read address = rd_ptr[S-2:0]
//  o_rd_data       out  W    read data (registered, holds last value)
//  o_rd_valid      out  1    o_rd_data is new this cycle (1-cycle pulse per read)
//  o_fifo_empty    out  1    FIFO empty (combinational)
//  o_almost_empty  out  1    level <= AE_THRESH (combinational)
//  o_level         out  S-1  current occupancy, 0..DEPTH (combinational)
//  o_underflow     out  1    sticky: read requested while empty
// BEHAVIOUR
//  - Reset (rd_clk edge with rd_rst=1): rd_ptr=0, o_rd_valid=0, pipeline stage-1 valid=0, o_rd_data=0, o_underflow=0.
//  - Reset has priority over every other event. An in-flight read is discarded: no o_rd_valid follows.
//  - Reset of rd_ptr and wr_ptr must coincide at system level.
//  - o_fifo_empty = (rd_ptr == wr_ptr), all S bits compared.
//  - Accept = rd_en & ~o_fifo_empty. On accept: mem_rd_en=1, mem_rd_addr=rd_ptr[S-2:0], and rd_ptr advances at the edge.
//  - When not accepting, mem_rd_en=0 and rd_ptr holds.
//  - Pointer advance:
//    - if rd_ptr[S-2:0] < DEPTH-1: index+1, wrap bit unchanged;
//    - if rd_ptr[S-2:0] == DEPTH-1: index becomes 0 and the wrap bit toggles.
//    - Index values >= DEPTH are never produced.
//  - Pipeline (accept in cycle N):
//    - stage-1 valid=1 during cycle N+1;
//    - at the end of cycle N+1, o_rd_data <= mem_rd_data;
//    - o_rd_valid=1 during cycle N+2.
//    - Latency is 2 cycles. Throughput is 1 read per cycle, so back-to-back accepts give back-to-back valids.
//  - There is no output backpressure: the consumer must take data whenever o_rd_valid is high.
//  - o_level:
//    - if wrap bits are equal: wr_ptr[S-2:0] - rd_ptr[S-2:0];
//    - otherwise: DEPTH - rd_ptr[S-2:0] + wr_ptr[S-2:0].
//    - Computed at S bits and truncated to S-1 bits.
//    - Full (wrap bits differ, indices equal) gives DEPTH.
//  - o_almost_empty = (o_level <= AE_THRESH); it is also high when empty.
//  - Underflow: rd_en & o_fifo_empty sets o_underflow at the edge. The read is ignored: the pointer holds and mem_rd_en=0.
//    o_underflow clears only on reset.
//  - Simultaneous write and read in the same cycle: empty and level use the pre-edge pointers.
//    A word written in cycle N is readable from cycle N+1.
// TESTING
//  1. Assert rd_rst for 1 edge with wr_ptr=0x000 -> rd_ptr=0x000, o_fifo_empty=1, o_level=0, o_rd_valid=0, o_underflow=0.
//  2. wr_ptr=0x003, rd_en=1 for 3 cycles from cycle 0 ->
//     mem_rd_addr=0,1,2; o_rd_valid high in cycles 2,3,4 with data mem[0..2]; o_fifo_empty=1 from cycle 3.
//  3. rd_ptr at 0x095 (index 149), wr_ptr=0x801, rd_en=1 ->
//     rd_ptr becomes 0x800 (index 0, wrap bit set); o_level goes 2 -> 1.
//  4. Drive pointers rd=0x090, wr=0x805 -> o_level=11, o_almost_empty=0.
//     Then rd=0x090, wr=0x890 (full) -> o_level=150, o_fifo_empty=0.
//  5. Empty FIFO, rd_en=1 for 1 cycle -> o_underflow=1 and stays set, rd_ptr unchanged, mem_rd_en=0, no o_rd_valid.
//  6. Accept a read in cycle N, rd_rst=1 in cycle N+1 ->
//     o_rd_valid stays 0 in cycle N+2, rd_ptr=0, o_rd_data=0.

Source files
------------

// File: rtl/fifo_read_unit.sv
// Read-side controller of the shared-clock FIFO: owns rd_ptr, derives the empty/level flags
// and returns read data from the synchronous-read buffer through a 2-stage pipeline.
module fifo_read_unit #(
    parameter int S         = 12,
    parameter int DEPTH     = 150,
    parameter int W         = 8,
    parameter int AE_THRESH = 4
) (
    input  logic         rd_clk,
    input  logic         rd_rst,
    input  logic         rd_en,
    input  logic [S-1:0] wr_ptr,
    input  logic [W-1:0] mem_rd_data,
    output logic [S-1:0] rd_ptr,
    output logic         mem_rd_en,
    output logic [S-2:0] mem_rd_addr,
    output logic [W-1:0] o_rd_data,
    output logic         o_rd_valid,
    output logic         o_fifo_empty,
    output logic         o_almost_empty,
    output logic [S-2:0] o_level,
    output logic         o_underflow
);

    localparam logic [S-2:0] LAST_IDX = (S-1)'(DEPTH - 1);
    localparam logic [S-2:0] DEPTH_V  = (S-1)'(DEPTH);
    localparam logic [S-2:0] AE_V     = (S-1)'(AE_THRESH);

    logic [S-1:0] rd_ptr_reg, rd_ptr_next;
    logic         s1_valid_reg;
    logic [W-1:0] rd_data_reg;
    logic         rd_valid_reg;
    logic         underflow_reg;
    logic         accept;
    logic         rd_wrap, wr_wrap;
    logic [S-2:0] rd_idx, wr_idx;

    assign rd_wrap = rd_ptr_reg[S-1];
    assign wr_wrap = wr_ptr[S-1];
    assign rd_idx  = rd_ptr_reg[S-2:0];
    assign wr_idx  = wr_ptr[S-2:0];

    assign o_fifo_empty = (rd_ptr_reg == wr_ptr);
    assign accept       = rd_en & ~o_fifo_empty;

    // Level arithmetic is modular, so computing it at S-1 bits equals the S-bit result truncated.
    always_comb begin
        if (rd_wrap == wr_wrap)
            o_level = wr_idx - rd_idx;
        else
            o_level = DEPTH_V - rd_idx + wr_idx;
    end

    assign o_almost_empty = (o_level <= AE_V);

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (accept) begin
            if (rd_idx == LAST_IDX)
                rd_ptr_next = {~rd_wrap, {(S-1){1'b0}}};
            else
                rd_ptr_next = {rd_wrap, rd_idx + 1'b1};
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr_reg    <= '0;
            s1_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            s1_valid_reg <= accept;
            rd_valid_reg <= s1_valid_reg;
            // Memory data is valid the cycle after the strobe, i.e. while stage 1 is valid.
            if (s1_valid_reg)
                rd_data_reg <= mem_rd_data;
            if (rd_en && o_fifo_empty)
                underflow_reg <= 1'b1;
        end
    end

    assign rd_ptr      = rd_ptr_reg;
    assign mem_rd_en   = accept;
    assign mem_rd_addr = rd_idx;
    assign o_rd_data   = rd_data_reg;
    assign o_rd_valid  = rd_valid_reg;
    assign o_underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_read_unit.sv
// Directed bench for fifo_read_unit with a behavioural synchronous-read memory.
module tb_fifo_read_unit;

    localparam int S = 12;
    localparam int W = 8;

    logic         rd_clk = 1'b0;
    logic         rd_rst = 1'b0;
    logic         rd_en  = 1'b0;
    logic [S-1:0] wr_ptr = '0;
    logic [W-1:0] mem_rd_data;
    logic [S-1:0] rd_ptr;
    logic         mem_rd_en;
    logic [S-2:0] mem_rd_addr;
    logic [W-1:0] o_rd_data;
    logic         o_rd_valid;
    logic         o_fifo_empty;
    logic         o_almost_empty;
    logic [S-2:0] o_level;
    logic         o_underflow;

    logic [W-1:0] mem [0:(1<<(S-1))-1];

    int passed = 0;
    int total  = 0;

    fifo_read_unit #(.S(S), .DEPTH(150), .W(W), .AE_THRESH(4)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .rd_en         (rd_en),
        .wr_ptr        (wr_ptr),
        .mem_rd_data   (mem_rd_data),
        .rd_ptr        (rd_ptr),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .o_fifo_empty  (o_fifo_empty),
        .o_almost_empty(o_almost_empty),
        .o_level       (o_level),
        .o_underflow   (o_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        if (mem_rd_en)
            mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        rd_en  = 1'b0;
        wr_ptr = '0;
        tick();
        rd_rst = 1'b0;
        #1;
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rd_ptr !== 12'h000) $display("FAIL reset_rd_ptr got %h want 000", rd_ptr); else passed++;
        total++; if (o_fifo_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", o_fifo_empty); else passed++;
        total++; if (o_level !== 11'd0) $display("FAIL reset_level got %0d want 0", o_level); else passed++;
        total++; if (o_rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_rd_valid); else passed++;
        total++; if (o_underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", o_underflow); else passed++;
        total++; if (o_almost_empty !== 1'b1) $display("FAIL reset_almost_empty got %b want 1", o_almost_empty); else passed++;
        $display("test_reset done: rd_ptr=%h empty=%b level=%0d", rd_ptr, o_fifo_empty, o_level);
    endtask

    task automatic test_back_to_back();
        logic [S-2:0] exp_addr [0:2];
        logic [W-1:0] exp_data [2:4];
        exp_addr[0] = 11'd0; exp_addr[1] = 11'd1; exp_addr[2] = 11'd2;
        exp_data[2] = 8'h30; exp_data[3] = 8'h31; exp_data[4] = 8'h32;
        do_reset();
        wr_ptr = 12'h003;
        for (int c = 0; c <= 5; c++) begin
            rd_en = (c < 3);
            #1;
            if (c < 3) begin
                total++;
                if (mem_rd_addr !== exp_addr[c] || mem_rd_en !== 1'b1)
                    $display("FAIL b2b_addr c%0d got addr=%0d en=%b want addr=%0d en=1", c, mem_rd_addr, mem_rd_en, exp_addr[c]);
                else passed++;
            end
            if (c >= 2 && c <= 4) begin
                total++;
                if (o_rd_valid !== 1'b1 || o_rd_data !== exp_data[c])
                    $display("FAIL b2b_data c%0d got valid=%b data=%h want valid=1 data=%h", c, o_rd_valid, o_rd_data, exp_data[c]);
                else passed++;
            end else begin
                total++;
                if (o_rd_valid !== 1'b0) $display("FAIL b2b_novalid c%0d got %b want 0", c, o_rd_valid); else passed++;
            end
            total++;
            if (o_fifo_empty !== (c >= 3)) $display("FAIL b2b_empty c%0d got %b want %b", c, o_fifo_empty, (c >= 3));
            else passed++;
            $display("b2b cycle %0d: addr=%0d en=%b valid=%b data=%h empty=%b", c, mem_rd_addr, mem_rd_en, o_rd_valid, o_rd_data, o_fifo_empty);
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        wr_ptr = 12'h095;
        read_n(149);
        total++; if (rd_ptr !== 12'h095) $display("FAIL wrap_pre_ptr got %h want 095", rd_ptr); else passed++;
        wr_ptr = 12'h801;
        #1;
        total++; if (o_level !== 11'd2) $display("FAIL wrap_level_pre got %0d want 2", o_level); else passed++;
        rd_en = 1'b1;
        #1;
        total++; if (mem_rd_addr !== 11'd149) $display("FAIL wrap_addr got %0d want 149", mem_rd_addr); else passed++;
        tick();
        rd_en = 1'b0;
        #1;
        total++; if (rd_ptr !== 12'h800) $display("FAIL wrap_ptr got %h want 800", rd_ptr); else passed++;
        total++; if (o_level !== 11'd1) $display("FAIL wrap_level_post got %0d want 1", o_level); else passed++;
        $display("test_wrap: rd_ptr=%h level=%0d", rd_ptr, o_level);
    endtask

    task automatic test_level();
        do_reset();
        wr_ptr = 12'h090;
        read_n(144);
        wr_ptr = 12'h805;
        #1;
        total++; if (rd_ptr !== 12'h090) $display("FAIL level_ptr got %h want 090", rd_ptr); else passed++;
        total++; if (o_level !== 11'd11) $display("FAIL level_11 got %0d want 11", o_level); else passed++;
        total++; if (o_almost_empty !== 1'b0) $display("FAIL level_ae got %b want 0", o_almost_empty); else passed++;
        wr_ptr = 12'h890;
        #1;
        total++; if (o_level !== 11'd150) $display("FAIL level_full got %0d want 150", o_level); else passed++;
        total++; if (o_fifo_empty !== 1'b0) $display("FAIL level_full_empty got %b want 0", o_fifo_empty); else passed++;
        wr_ptr = 12'h094;
        #1;
        total++; if (o_almost_empty !== 1'b1 || o_level !== 11'd4)
            $display("FAIL level_ae_edge got ae=%b level=%0d want ae=1 level=4", o_almost_empty, o_level);
        else passed++;
        wr_ptr = 12'h095;
        #1;
        total++; if (o_almost_empty !== 1'b0) $display("FAIL level_ae_5 got %b want 0", o_almost_empty); else passed++;
        $display("test_level: level=%0d ae=%b", o_level, o_almost_empty);
    endtask

    task automatic test_underflow();
        do_reset();
        rd_en = 1'b1;
        #1;
        total++; if (mem_rd_en !== 1'b0) $display("FAIL uf_mem_en got %b want 0", mem_rd_en); else passed++;
        tick();
        rd_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (o_underflow !== 1'b1) $display("FAIL uf_sticky c%0d got %b want 1", c, o_underflow); else passed++;
            total++; if (rd_ptr !== 12'h000) $display("FAIL uf_ptr c%0d got %h want 000", c, rd_ptr); else passed++;
            total++; if (o_rd_valid !== 1'b0) $display("FAIL uf_valid c%0d got %b want 0", c, o_rd_valid); else passed++;
            tick();
        end
        $display("test_underflow: underflow=%b rd_ptr=%h", o_underflow, rd_ptr);
    endtask

    task automatic test_reset_inflight();
        do_reset();
        wr_ptr = 12'h002;
        read_n(1);
        // Load a known nonzero value into o_rd_data first so the reset clear is observable.
        tick();
        total++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h30)
            $display("FAIL rst_pre_data got valid=%b data=%h want valid=1 data=30", o_rd_valid, o_rd_data);
        else passed++;
        rd_en = 1'b1;
        tick();
        rd_en  = 1'b0;
        rd_rst = 1'b1;
        wr_ptr = '0;
        tick();
        rd_rst = 1'b0;
        #1;
        total++; if (o_rd_valid !== 1'b0) $display("FAIL rst_inflight_valid got %b want 0", o_rd_valid); else passed++;
        total++; if (rd_ptr !== 12'h000) $display("FAIL rst_inflight_ptr got %h want 000", rd_ptr); else passed++;
        total++; if (o_rd_data !== 8'h00) $display("FAIL rst_inflight_data got %h want 00", o_rd_data); else passed++;
        tick();
        total++; if (o_rd_valid !== 1'b0) $display("FAIL rst_inflight_valid2 got %b want 0", o_rd_valid); else passed++;
        $display("test_reset_inflight: valid=%b rd_ptr=%h data=%h", o_rd_valid, rd_ptr, o_rd_data);
    endtask

    initial begin
        for (int i = 0; i < (1 << (S-1)); i++)
            mem[i] = W'(8'h30 + i);
        mem_rd_data = '0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_level();
        test_underflow();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
